// File: rtl/hazard_unit.sv
// hazard_unit: load-use / memory-wait stall generation and EX-stage operand
// forwarding selects for the pipeline controller.
//   stall 1 = load-use bubble (freeze PC/P1/P2, flush P2)
//   stall 2 = memory wait     (freeze PC/P1/P2/P3, flush P3)
// Instruction-type encodings default to the core's riscv_defs values and are
// exposed as parameters so an integration with a different table can override.
module hazard_unit #(
  parameter int         TIMEOUT = 1024,  // memory-wait cycles before timeout_err (>=2)
  parameter int         CNT_W   = 16,    // width of stall_cycles
  parameter logic [2:0] R_TYPE  = 3'd0,
  parameter logic [2:0] I_TYPE  = 3'd1,
  parameter logic [2:0] S_TYPE  = 3'd2,
  parameter logic [2:0] L_TYPE  = 3'd3,
  parameter logic [2:0] U_TYPE  = 3'd5,
  parameter logic [2:0] J_TYPE  = 3'd6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic             uses_rs1_ID,
  input  logic             uses_rs2_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rs1_EX,
  input  logic [4:0]       rs2_EX,
  input  logic [4:0]       rd_EX,
  input  logic [4:0]       rd_MEM,
  input  logic [4:0]       rd_WB,
  input  logic [2:0]       typeEX,
  input  logic [2:0]       typeMEM,
  input  logic [2:0]       typeWB,
  input  logic             mem_ready,
  output logic [1:0]       stall,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  // wait_cnt only ever holds 0..TIMEOUT-1.
  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  localparam logic [1:0] STALL_NONE = 2'd0;
  localparam logic [1:0] STALL_LU   = 2'd1;
  localparam logic [1:0] STALL_MEM  = 2'd2;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_BUB   = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]      stall_raw;
  logic            mw, lu;

  // True when an instruction of this type writes its rd.
  function automatic logic writes_rd(input logic [2:0] t);
    return (t == L_TYPE) || (t == R_TYPE) || (t == I_TYPE) ||
           (t == U_TYPE) || (t == J_TYPE);
  endfunction

  // Forwarding select for one EX source; MEM beats WB, loads in MEM have no
  // result yet, and x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] rd_m,
                                         input logic [2:0] type_m,
                                         input logic [4:0] rd_w,
                                         input logic [2:0] type_w);
    if (src != 5'd0 && src == rd_m && writes_rd(type_m) && type_m != L_TYPE)
      return FWD_MEM;
    else if (src != 5'd0 && src == rd_w && writes_rd(type_w))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  // Hazard conditions seen by the FSM.
  always_comb begin
    mw = ((typeEX == L_TYPE) || (typeEX == S_TYPE)) && !mem_ready;
    lu = (typeEX == L_TYPE) && (rd_EX != 5'd0) &&
         ((uses_rs1_ID && rs1_ID == rd_EX) || (uses_rs2_ID && rs2_ID == rd_EX));
  end

  // Next-state, wait counter and raw stall code.
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_raw  = STALL_NONE;
    unique case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (redirect)  stall_raw = STALL_NONE;
        else if (mw)   stall_raw = STALL_MEM;
        else if (lu)   stall_raw = STALL_LU;
        if (stall_raw == STALL_MEM) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_ONE;
        end else if (stall_raw == STALL_LU) begin
          state_d = LU_BUB;
        end else begin
          state_d = IDLE;
        end
      end
      LU_BUB: begin
        // The bubble has already been inserted; a lingering LU is ignored.
        wait_cnt_d = '0;
        if (!redirect && mw) begin
          stall_raw  = STALL_MEM;
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      MEM_WAIT: begin
        if (!redirect && mw) begin
          stall_raw = STALL_MEM;
          if (wait_cnt_q == WC_LAST) begin
            state_d = ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_ONE;
          end
        end else begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end
      end
      ERR: begin
        // Terminal: memory port presumed dead, hold everything until reset.
        stall_raw = STALL_MEM;
        state_d   = ERR;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State and wait-counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall != STALL_NONE && stall_cycles != {CNT_W{1'b1}}) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held so a mid-stall reset
  // releases the pipeline in the same cycle.
  always_comb begin
    stall       = reset ? STALL_NONE : stall_raw;
    fwdA        = reset ? FWD_REG : fwd_sel(rs1_EX, rd_MEM, typeMEM, rd_WB, typeWB);
    fwdB        = reset ? FWD_REG : fwd_sel(rs2_EX, rd_MEM, typeMEM, rd_WB, typeWB);
    timeout_err = (state_q == ERR);
  end

  // Code 3 has no meaning to the controller.
  assert property (@(posedge clk) disable iff (reset) stall != 2'd3);

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors with hand-computed expectations. The driver
// pushes each vector's expected outputs into a scoreboard queue; a monitor on
// the falling edge pops and compares.
module tb_hazard_unit;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  localparam logic [2:0] R_T = 3'd0, I_T = 3'd1, S_T = 3'd2, L_T = 3'd3,
                         B_T = 3'd4, U_T = 3'd5, J_T = 3'd6, NOP_T = 3'd7;

  localparam int ST_IDLE = 0, ST_LU = 1, ST_WAIT = 2, ST_ERR = 3;
  localparam int SKIP = -1;

  logic             clk, reset, redirect, uses_rs1_ID, uses_rs2_ID, mem_ready;
  logic [4:0]       rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic [2:0]       typeEX, typeMEM, typeWB;
  logic [1:0]       stall, fwdA, fwdB;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  hazard_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .redirect(redirect),
    .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .rd_EX(rd_EX), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
    .typeEX(typeEX), .typeMEM(typeMEM), .typeWB(typeWB),
    .mem_ready(mem_ready), .stall(stall), .fwdA(fwdA), .fwdB(fwdB),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    stall, fwd_a, fwd_b, terr, sc, st, wc;  // SKIP = not checked
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input string field,
                       input int act, input int exp);
    if (exp != SKIP && act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
    end
  endtask

  // Monitor: compare outputs mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      check(e.name, "stall",        int'(stall),          e.stall);
      check(e.name, "fwdA",         int'(fwdA),           e.fwd_a);
      check(e.name, "fwdB",         int'(fwdB),           e.fwd_b);
      check(e.name, "timeout_err",  int'(timeout_err),    e.terr);
      check(e.name, "stall_cycles", int'(stall_cycles),   e.sc);
      check(e.name, "state",        int'(dut.state_q),    e.st);
      check(e.name, "wait_cnt",     int'(dut.wait_cnt_q), e.wc);
    end
  end

  // Push the expectation for the inputs currently applied, then advance.
  task automatic vec(input string name, input int s, input int fa, input int fb,
                     input int terr, input int sc, input int st, input int wc);
    exp_t e;
    e = '{name, s, fa, fb, terr, sc, st, wc};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    redirect = 1'b0; uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0; mem_ready = 1'b1;
    rs1_ID = '0; rs2_ID = '0; rs1_EX = '0; rs2_EX = '0;
    rd_EX = '0; rd_MEM = '0; rd_WB = '0;
    typeEX = NOP_T; typeMEM = NOP_T; typeWB = NOP_T;
  endtask

  task automatic load_use_rs2();
    quiet(); typeEX = L_T; rd_EX = 5'd7; uses_rs2_ID = 1'b1; rs2_ID = 5'd7;
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    @(posedge clk); #1;

    // Reset: forwarding inputs present but outputs held quiet.
    typeMEM = R_T; rd_MEM = 5'd5; rs1_EX = 5'd5;
    vec("rst_hold", 0, 0, 0, 0, 0, ST_IDLE, 0);
    reset = 1'b0;

    // Forwarding.
    quiet(); typeMEM = R_T; rd_MEM = 5'd5; rs1_EX = 5'd5;
    vec("fwd_mem", 0, 1, 0, 0, 0, ST_IDLE, 0);
    typeWB = I_T; rd_WB = 5'd5;
    vec("fwd_mem_prio", 0, 1, 0, 0, SKIP, SKIP, SKIP);
    typeMEM = L_T; rs2_EX = 5'd5;
    vec("fwd_load_skip", 0, 2, 2, 0, SKIP, SKIP, SKIP);
    typeMEM = S_T; typeWB = B_T;
    vec("fwd_no_write", 0, 0, 0, 0, SKIP, SKIP, SKIP);
    quiet(); typeMEM = R_T; typeWB = R_T;
    vec("fwd_x0", 0, 0, 0, 0, SKIP, SKIP, SKIP);
    quiet(); typeMEM = U_T; rd_MEM = 5'd3; rs1_EX = 5'd3;
    typeWB = J_T; rd_WB = 5'd9; rs2_EX = 5'd9;
    vec("fwd_split", 0, 1, 2, 0, 0, ST_IDLE, 0);

    // Load-use.
    quiet(); typeEX = L_T; uses_rs1_ID = 1'b1;
    vec("lu_rd_x0", 0, 0, 0, 0, 0, ST_IDLE, SKIP);
    quiet(); typeEX = L_T; rd_EX = 5'd7; rs1_ID = 5'd7;
    vec("lu_not_used", 0, 0, 0, 0, 0, ST_IDLE, SKIP);
    load_use_rs2();
    vec("lu_bubble", 1, 0, 0, 0, 0, ST_IDLE, SKIP);
    vec("lu_held", 0, 0, 0, 0, 1, ST_LU, SKIP);
    quiet();
    vec("lu_after", 0, 0, 0, 0, 1, ST_IDLE, SKIP);
    quiet(); typeEX = L_T; rd_EX = 5'd4; uses_rs1_ID = 1'b1; rs1_ID = 5'd4;
    vec("lu_rs1", 1, 0, 0, 0, 1, ST_IDLE, SKIP);
    quiet();
    vec("lu_rs1_bub", 0, 0, 0, 0, 2, ST_LU, SKIP);
    vec("lu_rs1_done", 0, 0, 0, 0, 2, ST_IDLE, SKIP);

    // Memory wait, three cycles.
    quiet(); typeEX = S_T; mem_ready = 1'b0;
    vec("mw_1", 2, 0, 0, 0, 2, ST_IDLE, 0);
    vec("mw_2", 2, 0, 0, 0, 3, ST_WAIT, 1);
    vec("mw_3", 2, 0, 0, 0, 4, ST_WAIT, 2);
    mem_ready = 1'b1;
    vec("mw_ready", 0, 0, 0, 0, 5, ST_WAIT, 2 + 1);
    quiet();
    vec("mw_idle", 0, 0, 0, 0, 5, ST_IDLE, 0);

    // Redirect while waiting, then while a load-use is pending.
    quiet(); typeEX = L_T; mem_ready = 1'b0;
    vec("rd_w1", 2, 0, 0, 0, 5, ST_IDLE, 0);
    vec("rd_w2", 2, 0, 0, 0, 6, ST_WAIT, 1);
    redirect = 1'b1;
    vec("rd_pulse", 0, 0, 0, 0, 7, ST_WAIT, 2);
    quiet();
    vec("rd_after", 0, 0, 0, 0, 7, ST_IDLE, 0);
    load_use_rs2(); redirect = 1'b1;
    vec("rd_over_lu", 0, 0, 0, 0, 7, ST_IDLE, 0);
    quiet();
    vec("rd_lu_after", 0, 0, 0, 0, 7, ST_IDLE, 0);

    // Bubble state escalating to a memory wait.
    load_use_rs2();
    vec("bub_lu", 1, 0, 0, 0, 7, ST_IDLE, SKIP);
    mem_ready = 1'b0;
    vec("bub_mw", 2, 0, 0, 0, 8, ST_LU, SKIP);
    quiet();
    vec("bub_mw_end", 0, 0, 0, 0, 9, ST_WAIT, 1);
    vec("bub_idle", 0, 0, 0, 0, 9, ST_IDLE, 0);

    // Timeout after 4 stalled cycles, then counter saturation in ERR.
    quiet(); typeEX = S_T; mem_ready = 1'b0;
    vec("to_1", 2, 0, 0, 0, 9,  ST_IDLE, 0);
    vec("to_2", 2, 0, 0, 0, 10, ST_WAIT, 1);
    vec("to_3", 2, 0, 0, 0, 11, ST_WAIT, 2);
    vec("to_4", 2, 0, 0, 0, 12, ST_WAIT, 3);
    quiet(); redirect = 1'b1;
    vec("err_redirect", 2, 0, 0, 1, 13, ST_ERR, SKIP);
    quiet();
    vec("err_hold", 2, 0, 0, 1, 14, ST_ERR, SKIP);
    for (int i = 0; i < 6; i++) vec("sat", 2, 0, 0, 1, 15, ST_ERR, SKIP);

    // Asynchronous reset in the middle of a stall.
    typeEX = S_T; mem_ready = 1'b0; typeMEM = R_T; rd_MEM = 5'd5; rs1_EX = 5'd5;
    reset = 1'b1;
    vec("rst_mid", 0, 0, 0, 0, 0, ST_IDLE, 0);
    reset = 1'b0;
    quiet();
    vec("rst_release", 0, 0, 0, 0, 0, ST_IDLE, 0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
